// File: rtl/conv2d_mac_engine_pkg.sv
// Shared types and helpers for the single-MAC conv2d engine.
// State encoding, default tap/weight counts, requantisation helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        BIAS,
        EMIT
    } state_t;

    localparam int C_IN_DEF  = 3;
    localparam int K_DEF     = 3;
    localparam int C_OUT_DEF = 8;
    localparam int N_TAPS    = C_IN_DEF * K_DEF * K_DEF;
    localparam int N_WGT     = C_OUT_DEF * N_TAPS;

    // Round half up (only for shift > 0), arithmetic shift, clamp to out_w.
    function automatic logic signed [63:0] sat_round(
        input logic signed [63:0] acc,
        input int                 shift,
        input int                 out_w
    );
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = acc;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/conv2d_mac_engine_requant.sv
// Combinational round/shift/saturate stage for the conv2d engine.
// Define CONV_RELU_EN to clamp negative results to zero after saturation.
module conv_requant #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] res
);
    import conv_pkg::*;

    logic signed [OUT_W-1:0] sat;

    assign sat = OUT_W'(sat_round(64'(sum), SHIFT, OUT_W));

`ifdef CONV_RELU_EN
    assign res = sat[OUT_W-1] ? '0 : sat;
`else
    assign res = sat;
`endif

endmodule

// File: rtl/conv2d_mac_engine.sv
// Single-MAC 2D convolution engine with ready/valid flow and coefficient RAMs.
// Optional fused ReLU selected by CONV_RELU_EN (inside conv_requant).
module conv2d_mac_engine #(
    parameter int DATA_W = 8,
    parameter int W_W    = 16,
    parameter int B_W    = 32,
    parameter int ACC_W  = 48,
    parameter int OUT_W  = 16,
    parameter int C_IN   = 3,
    parameter int C_OUT  = 8,
    parameter int K      = 3,
    parameter int SHIFT  = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wgt_we,
    input  logic [$clog2(C_OUT*C_IN*K*K)-1:0]    wgt_addr,
    input  logic signed [W_W-1:0]                wgt_data,
    input  logic                                 bias_we,
    input  logic [$clog2(C_OUT)-1:0]             bias_addr,
    input  logic signed [B_W-1:0]                bias_data,
    input  logic                                 win_valid,
    output logic                                 win_ready,
    input  logic [C_IN*K*K*DATA_W-1:0]           win_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [OUT_W-1:0]              out_data,
    output logic [$clog2(C_OUT)-1:0]             out_ch,
    output logic                                 out_last,
    output logic                                 busy
);
    import conv_pkg::*;

    localparam int NT = C_IN * K * K;
    localparam int NW = C_OUT * NT;
    localparam int WA = $clog2(NW);
    localparam int CW = $clog2(C_OUT);
    localparam int IW = (NT > 1) ? $clog2(NT) : 1;
    localparam int PW = DATA_W + 1 + W_W;

    logic signed [W_W-1:0]     wgt  [NW];
    logic signed [B_W-1:0]     bias [C_OUT];
    logic [NT*DATA_W-1:0]      win;
    state_t                    state;
    logic [CW-1:0]             co;
    logic [IW-1:0]             idx;
    logic signed [ACC_W-1:0]   acc;
    logic [WA-1:0]             waddr;
    logic [DATA_W-1:0]         pix;
    logic signed [W_W-1:0]     w;
    logic signed [PW-1:0]      prod;
    logic signed [ACC_W-1:0]   sum;
    logic signed [OUT_W-1:0]   q;

    assign win_ready = rst_n && (state == IDLE);

    assign waddr = WA'(int'(co) * NT + int'(idx));
    assign pix   = win[idx*DATA_W +: DATA_W];
    assign w     = wgt[waddr];
    assign prod  = $signed({1'b0, pix}) * w;
    assign sum   = acc + ACC_W'(bias[co]);

    conv_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .sum (sum),
        .res (q)
    );

    // Coefficients are frozen while a window is in flight.
    always_ff @(posedge clk) begin
        if (wgt_we && !busy && int'(wgt_addr) < NW) begin
            wgt[wgt_addr] <= wgt_data;
        end
        if (bias_we && !busy && int'(bias_addr) < C_OUT) begin
            bias[bias_addr] <= bias_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            co        <= '0;
            idx       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_valid) begin
                        win   <= win_data;
                        co    <= '0;
                        idx   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    if (int'(idx) == NT - 1) begin
                        idx   <= '0;
                        state <= BIAS;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                BIAS: begin
                    out_data  <= q;
                    out_ch    <= co;
                    out_last  <= (int'(co) == C_OUT - 1);
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (int'(co) == C_OUT - 1) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            co    <= co + 1'b1;
                            acc   <= '0;
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2d_mac_engine.sv
// Scoreboard bench for conv2d_mac_engine: SHIFT=0 and SHIFT=2 instances in lockstep.
// Expected results pushed at window issue; a monitor pops on each output handshake.
module tb_conv2d_mac_engine;

    localparam int NT  = 27;
    localparam int NCO = 8;
    localparam int DW  = 8;

    typedef struct {
        int data;
        int ch;
        bit last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic wgt_we = 1'b0;
    logic [7:0] wgt_addr = '0;
    logic signed [15:0] wgt_data = '0;
    logic bias_we = 1'b0;
    logic [2:0] bias_addr = '0;
    logic signed [31:0] bias_data = '0;
    logic win_valid = 1'b0;
    logic [NT*DW-1:0] win_data = '0;
    logic out_ready = 1'b1;

    logic win_ready [2];
    logic out_valid [2];
    logic out_last [2];
    logic busy [2];
    logic signed [15:0] out_data [2];
    logic [2:0] out_ch [2];

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    conv2d_mac_engine u0 (
        .clk(clk), .rst_n(rst_n),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .win_valid(win_valid), .win_ready(win_ready[0]), .win_data(win_data),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_data(out_data[0]), .out_ch(out_ch[0]),
        .out_last(out_last[0]), .busy(busy[0])
    );

    conv2d_mac_engine #(.SHIFT(2)) u1 (
        .clk(clk), .rst_n(rst_n),
        .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_data(wgt_data),
        .bias_we(bias_we), .bias_addr(bias_addr), .bias_data(bias_data),
        .win_valid(win_valid), .win_ready(win_ready[1]), .win_data(win_data),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_data(out_data[1]), .out_ch(out_ch[1]),
        .out_last(out_last[1]), .busy(busy[1])
    );

    function automatic int relu(int v);
`ifdef CONV_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_ch(int ch, int e0, int e1);
        exp_t e;
        e.ch = ch;
        e.last = (ch == NCO - 1);
        e.data = e0;
        q0.push_back(e);
        e.data = e1;
        q1.push_back(e);
    endtask

    task automatic push_win(int e0, int e1);
        for (int c = 0; c < NCO; c++) push_ch(c, e0, e1);
    endtask

    // Pops on every accepted output of either instance.
    always begin
        @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && out_valid[d] && out_ready) begin
                exp_t e;
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out dut%0d: got ch %0d data %0d, expected none",
                             d, out_ch[d], out_data[d]);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("data%0d_ch%0d", d, e.ch), int'(out_data[d]), e.data);
                    check($sformatf("ch%0d", d), int'(out_ch[d]), e.ch);
                    check($sformatf("last%0d_ch%0d", d, e.ch), int'(out_last[d]), int'(e.last));
                end
            end
        end
    end

    task automatic wr_w(int a, int v);
        @(negedge clk);
        wgt_we = 1'b1;
        wgt_addr = a[7:0];
        wgt_data = v[15:0];
        @(posedge clk);
        #1;
        wgt_we = 1'b0;
    endtask

    task automatic set_wgts(int v);
        for (int i = 0; i < NCO * NT; i++) wr_w(i, v);
    endtask

    task automatic set_bias(int v);
        for (int i = 0; i < NCO; i++) begin
            @(negedge clk);
            bias_we = 1'b1;
            bias_addr = i[2:0];
            bias_data = v;
            @(posedge clk);
            #1;
            bias_we = 1'b0;
        end
    endtask

    task automatic send_win(int pix, output int hs);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        win_valid = 1'b1;
        for (int i = 0; i < NT; i++) win_data[i*DW +: DW] = pix[DW-1:0];
        for (int t = 0; t < 600; t++) begin
            if (win_ready[0]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL win_handshake: got timeout, expected win_ready");
        end
        @(posedge clk);
        #1;
        hs = cyc;
        win_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (win_ready[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy, expected idle");
        end
    endtask

    task automatic stall_ch3();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 600; t++) begin
            @(negedge clk);
            if (out_valid[0] && out_ch[0] == 3'd3) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL stall_find: got no ch3, expected ch3 valid");
        end
        out_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", int'(out_valid[0]), 1);
            check("stall_data", int'(out_data[0]), 10);
            check("stall_ch", int'(out_ch[0]), 3);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int h0;
        int h1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_win_ready", int'(win_ready[0]), 0);
        check("rst_out_valid", int'(out_valid[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        check("rst_out_data", int'(out_data[0]), 0);
        check("rst_out_ch", int'(out_ch[0]), 0);
        check("rst_out_last", int'(out_last[0]), 0);
        rst_n = 1'b1;

        // All-ones: 27 taps of 1*1; SHIFT=2 gives (27+2)>>2 = 7.
        set_wgts(1);
        set_bias(0);
        send_win(1, h0);
        push_win(27, 7);
        send_win(1, h1);
        push_win(27, 7);
        check("period", h1 - h0, NCO * (NT + 2) + 1);

        wait_idle();
        set_wgts(32767);
        send_win(255, h0);
        push_win(32767, 32767);
        wait_idle();
        set_wgts(-32768);
        send_win(255, h0);
        push_win(relu(-32768), relu(-32768));

        // Single tap per channel: 6 -> 6 / 2, -6 -> -6 / -1, 6+4 -> 10 / 3.
        wait_idle();
        set_wgts(0);
        for (int c = 0; c < NCO; c++) wr_w(c * NT, 6);
        send_win(1, h0);
        push_win(6, 2);
        wait_idle();
        for (int c = 0; c < NCO; c++) wr_w(c * NT, -6);
        send_win(1, h0);
        push_win(relu(-6), relu(-1));
        wait_idle();
        for (int c = 0; c < NCO; c++) wr_w(c * NT, 6);
        set_bias(4);
        send_win(1, h0);
        push_win(10, 3);

        wait_idle();
        send_win(1, h0);
        push_win(10, 3);
        fork
            stall_ch3();
            send_win(1, h1);
        join
        push_win(10, 3);
        check("period_stall", h1 - h0, NCO * (NT + 2) + 1 + 5);

        // Busy write dropped; idle write used: 100+4 -> 104 / 26.
        wait_idle();
        send_win(1, h0);
        wr_w(0, 100);
        push_win(10, 3);
        wait_idle();
        wr_w(0, 100);
        send_win(1, h0);
        push_ch(0, 104, 26);
        for (int c = 1; c < NCO; c++) push_ch(c, 10, 3);

        wait_idle();
        set_wgts(1);
        set_bias(0);
        send_win(1, h0);
        push_ch(0, 27, 7);
        push_ch(1, 27, 7);
        repeat (68) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", int'(out_valid[0]), 0);
        check("post_rst_ready", int'(win_ready[0]), 1);
        check("post_rst_busy", int'(busy[1]), 0);
        send_win(1, h0);
        push_win(27, 7);

        for (int t = 0; t < 600; t++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        repeat (40) @(negedge clk);
        check("q0_left", q0.size(), 0);
        check("q1_left", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
